store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- Store-side counterpart of the register file's load-formatting write path.
- Takes a store request (opcode, effective address, 64-bit source-register data) and formats it onto a 32-bit big-endian data-memory write port.
- Handles byte, half, word and doubleword stores; a doubleword is issued as two beats.
- Sits between the ALU/register-read stage and data memory. Valid/ready handshakes on both sides.

Parameters:
- ADDR_W, 64, width of request address and mem_addr.
- TIMEOUT_CYCLES, 16, watchdog limit in cycles; used only with STORE_UNIT_TIMEOUT_EN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- opcode  input  6  store opcode: 38 stb, 44 sth, 36 stw, 62 std.
- addr  input  ADDR_W  effective byte address.
- store_data  input  64  source register contents (ReadData2).
- mem_valid  output  1  write beat valid.
- mem_ready  input  1  memory accepts the beat.
- mem_addr  output  ADDR_W  word-aligned address (low 2 bits = 0).
- mem_wdata  output  32  write data, big-endian lanes.
- mem_be  output  4  byte enables; bit 3 = lane at byte offset 0.
- done  output  1  one-cycle pulse at store completion.
- err  output  1  qualifies done: misaligned address, illegal opcode, or timeout.

Behaviour:
- Reset values: req_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0, err=0. FSM returns to IDLE.
- Reset mid-operation abandons the transfer immediately, with no done pulse.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE: a request is accepted when req_valid && req_ready. Opcode, addr and store_data are latched on the accept edge.
  - Illegal request -> RESP with err=1, and no memory beat is issued.
  - Otherwise -> BEAT0.
- Illegal request: an opcode outside {38,44,36,62}, or misalignment: sth with addr[0]!=0, stw with addr[1:0]!=0, std with addr[2:0]!=0.
- BEAT0: mem_valid=1; outputs are held stable until mem_ready.
  - On mem_valid && mem_ready: std -> BEAT1, all others -> RESP.
- BEAT1 (std only): mem_addr = latched addr + 4 (low 2 bits forced to 0), mem_wdata = store_data[31:0], mem_be=4'b1111. On handshake -> RESP.
- RESP: done=1 for exactly one cycle, err as determined, mem_valid=0 -> IDLE.
- req_ready is low in BEAT0, BEAT1 and RESP, so back-to-back requests are spaced by at least one IDLE cycle.
- Lane mapping, with k = addr[1:0]:
  - stb: data byte store_data[7:0] placed at mem_wdata[31-8k -: 8]; mem_be = 4'b1000 >> k.
  - sth: store_data[15:0] placed at mem_wdata[31-8k -: 16] (k is 0 or 2); mem_be = 4'b1100 >> k.
  - stw: mem_wdata = store_data[31:0]; mem_be=4'b1111.
  - std BEAT0: mem_wdata = store_data[63:32]; mem_be=4'b1111.
- Unused lanes of mem_wdata are driven 0. mem_addr = {addr[ADDR_W-1:2], 2'b00}.
- Latency: accept at edge N, mem_valid high from cycle N+1. With mem_ready held high:
  - single-beat store: done in cycle N+2.
  - std: done in cycle N+3.
  - illegal request: done+err in cycle N+1.
- mem_ready asserted while mem_valid=0 is ignored.
- Address + 4 wraps modulo 2^ADDR_W with no error.

Optional Feature:
- Macro: STORE_UNIT_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BEAT0/BEAT1 and increments each cycle mem_valid && !mem_ready.
  - Reaching TIMEOUT_CYCLES drops mem_valid and goes to RESP with err=1. For std this can occur on either beat; a completed BEAT0 is not rolled back.
- Undefined: no counter; the unit waits indefinitely for mem_ready.

Test Plan:
- stb: opcode 38, addr 0x1003, data 0xAB, mem_ready=1 -> one beat, mem_addr 0x1000, mem_be 0001, mem_wdata 0x000000AB; done at N+2, err=0.
- sth: opcode 44, addr 0x2002, data 0x1234 -> mem_be 0011, mem_wdata 0x00001234. Same opcode with addr 0x2001 -> no mem_valid; done+err at N+1.
- std: opcode 62, addr 0x3000, data 0x1122334455667788, mem_ready low 3 cycles on beat0 -> beat0 held stable at 0x3000/0x11223344; then beat1 at 0x3004/0x55667788 with be 1111; single done.
- Illegal: opcode 34 -> done+err, no memory traffic; req_ready low in RESP cycle, high in the next.
- Reset: rst asserted in BEAT1 of an std -> next cycle all outputs at reset values, no done; a fresh stw then completes normally.
- With STORE_UNIT_TIMEOUT_EN, TIMEOUT_CYCLES=4: stw with mem_ready stuck low -> mem_valid drops after 4 stall cycles; done+err=1.

Source files
------------

// File: rtl/store_unit.sv
// Formats 64-bit store requests onto a 32-bit big-endian data-memory write port.
// Optional write-beat watchdog enabled by defining STORE_UNIT_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a request
// BEAT0 | first (or only) write beat on the memory port
// BEAT1 | second word of a doubleword store
// RESP  | one-cycle done pulse, err qualifies it
module store_unit #(
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       store_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  localparam logic [5:0] OP_STB = 6'd38;
  localparam logic [5:0] OP_STH = 6'd44;
  localparam logic [5:0] OP_STW = 6'd36;
  localparam logic [5:0] OP_STD = 6'd62;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t            state, state_nxt;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       data_q;
  logic              err_q;
  logic              accept;
  logic              req_illegal;
  logic              timeout_hit;

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    req_illegal = 1'b0;
    case (opcode)
      OP_STB:  req_illegal = 1'b0;
      OP_STH:  req_illegal = addr[0];
      OP_STW:  req_illegal = |addr[1:0];
      OP_STD:  req_illegal = |addr[2:0];
      default: req_illegal = 1'b1;
    endcase
  end

`ifdef STORE_UNIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] stall_cnt;

  // Any cycle without a stalled beat (idle, handshake, resp) clears the count,
  // which covers entry into both beat states.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (mem_valid && !mem_ready) begin
      stall_cnt <= stall_cnt + 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end

  assign timeout_hit = mem_valid && !mem_ready && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= opcode;
        addr_q <= addr;
        data_q <= store_data;
        err_q  <= req_illegal;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = req_illegal ? RESP : BEAT0;
      end
      BEAT0: begin
        if (timeout_hit)    state_nxt = RESP;
        else if (mem_ready) state_nxt = (op_q == OP_STD) ? BEAT1 : RESP;
      end
      BEAT1: begin
        if (timeout_hit || mem_ready) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    done      = (state == RESP);
    err       = (state == RESP) && err_q;
    case (state)
      BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        case (op_q)
          OP_STB: begin
            mem_wdata = {data_q[7:0], 24'h0} >> {addr_q[1:0], 3'b000};
            mem_be    = 4'b1000 >> addr_q[1:0];
          end
          OP_STH: begin
            mem_wdata = {data_q[15:0], 16'h0} >> {addr_q[1:0], 3'b000};
            mem_be    = 4'b1100 >> addr_q[1:0];
          end
          OP_STD: begin
            mem_wdata = data_q[63:32];
            mem_be    = 4'b1111;
          end
          default: begin
            mem_wdata = data_q[31:0];
            mem_be    = 4'b1111;
          end
        endcase
      end
      BEAT1: begin
        mem_valid = 1'b1;
        // Next word wraps modulo 2^ADDR_W by construction.
        mem_addr  = {addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00};
        mem_wdata = data_q[31:0];
        mem_be    = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: directed stores push expected beats/done,
// a negedge monitor compares whatever the DUT presents.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  opcode;
  logic [63:0] addr;
  logic [63:0] store_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [63:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        err;

  typedef struct {
    bit          is_done;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  store_unit #(.ADDR_W(64), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .addr(addr), .store_data(store_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_beat(input logic [63:0] a, input logic [31:0] w, input logic [3:0] be);
    exp_t e;
    e.is_done = 1'b0; e.addr = a; e.wdata = w; e.be = be; e.err = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_done(input logic e_err);
    exp_t e;
    e.is_done = 1'b1; e.addr = '0; e.wdata = '0; e.be = '0; e.err = e_err;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_valid) begin
        if (q.size() == 0 || q[0].is_done) begin
          chk("unexpected_beat", {32'h0, mem_wdata}, 64'hDEAD_0000);
        end else begin
          chk("mem_addr", mem_addr, q[0].addr);
          chk("mem_wdata", {32'h0, mem_wdata}, {32'h0, q[0].wdata});
          chk("mem_be", {60'h0, mem_be}, {60'h0, q[0].be});
          if (mem_ready) void'(q.pop_front());
        end
      end
      if (done) begin
        if (q.size() == 0 || !q[0].is_done) begin
          chk("unexpected_done", {63'h0, err}, 64'hDEAD_0001);
        end else begin
          chk("err", {63'h0, err}, {63'h0, q[0].err});
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [5:0] op, input logic [63:0] a, input logic [63:0] d);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("req_ready_wait", {63'h0, req_ready}, 64'h1);
    req_valid = 1'b1; opcode = op; addr = a; store_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // After the accept edge, cycle c=1 is the first post-accept cycle.
  task automatic run(input logic [5:0] op, input logic [63:0] a, input logic [63:0] d,
                     input int lat, input int stall0);
    int c;
    bit got;
    mem_ready = (stall0 == 0);
    @(posedge clk); #1;
    issue(op, a, d);
    c = 1; got = 0;
    while (c <= 40 && !got) begin
      if (c > stall0) mem_ready = 1'b1;
      if (done) got = 1;
      else begin
        @(posedge clk); #1; c++;
      end
    end
    chk("done_latency", c, lat);
    chk("req_ready_in_resp", {63'h0, req_ready}, 64'h0);
    @(posedge clk); #1;
    chk("req_ready_after_resp", {63'h0, req_ready}, 64'h1);
    chk("done_one_cycle", {63'h0, done}, 64'h0);
    mem_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; opcode = '0; addr = '0; store_data = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, err},
        {1'b1, 1'b0, 64'h0, 32'h0, 4'h0, 1'b0, 1'b0});
    rst = 1'b0;

    push_beat(64'h1000, 32'h0000_00AB, 4'b0001); push_done(1'b0);
    run(6'd38, 64'h1003, 64'hAB, 2, 0);
    push_beat(64'h1000, 32'h005A_0000, 4'b0100); push_done(1'b0);
    run(6'd38, 64'h1001, 64'h5A, 2, 0);
    push_beat(64'h5000, 32'hEE00_0000, 4'b1000); push_done(1'b0);
    run(6'd38, 64'h5000, 64'hFFEE, 2, 0);
    push_beat(64'h2000, 32'h0000_1234, 4'b0011); push_done(1'b0);
    run(6'd44, 64'h2002, 64'h1234, 2, 0);
    push_beat(64'h6000, 32'hBEEF_0000, 4'b1100); push_done(1'b0);
    run(6'd44, 64'h6000, 64'hBEEF, 2, 0);
    push_done(1'b1);
    run(6'd44, 64'h2001, 64'h1234, 1, 0);
    push_beat(64'h7004, 32'hCAFE_F00D, 4'b1111); push_done(1'b0);
    run(6'd36, 64'h7004, 64'hDEAD_BEEF_CAFE_F00D, 2, 0);
    push_done(1'b1);
    run(6'd36, 64'h7002, 64'h1, 1, 0);
    push_beat(64'h3000, 32'h1122_3344, 4'b1111);
    push_beat(64'h3004, 32'h5566_7788, 4'b1111); push_done(1'b0);
    run(6'd62, 64'h3000, 64'h1122_3344_5566_7788, 6, 3);
    push_beat(64'hFFFF_FFFF_FFFF_FFF8, 32'h0102_0304, 4'b1111);
    push_beat(64'hFFFF_FFFF_FFFF_FFFC, 32'h0506_0708, 4'b1111); push_done(1'b0);
    run(6'd62, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0102_0304_0506_0708, 3, 0);
    push_done(1'b1);
    run(6'd62, 64'h3004, 64'h0, 1, 0);
    push_done(1'b1);
    run(6'd34, 64'h4000, 64'h0, 1, 0);

    // Reset while the second std beat is pending.
    push_beat(64'h9000, 32'hA1A2_A3A4, 4'b1111);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    issue(6'd62, 64'h9000, 64'hA1A2_A3A4_B1B2_B3B4);
    @(posedge clk); #1;
    chk("in_beat1", {63'h0, mem_valid}, 64'h1);
    rst = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_mid_std", {req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, err},
        {1'b1, 1'b0, 64'h0, 32'h0, 4'h0, 1'b0, 1'b0});
    chk("queue_after_reset", q.size(), 0);
    push_beat(64'h8000, 32'h1234_5678, 4'b1111); push_done(1'b0);
    run(6'd36, 64'h8000, 64'h1234_5678, 2, 0);

`ifdef STORE_UNIT_TIMEOUT_EN
    push_beat(64'hA000, 32'h7777_8888, 4'b1111); push_done(1'b1);
    run(6'd36, 64'hA000, 64'h7777_8888, 5, 1000);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
